// File: rtl/bind_kernel.sv
// bind_kernel: compute-side responder of the mapper-to-kernel stream.
// Folds one word slice of each operand hypervector per accepted beat into a
// bound result (XOR, XNOR or rotate-then-XOR). It then holds that result on
// k_data_out with k_done high until the next bind starts.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   k_valid    beat present on k_data_in
//   k_first    beat is the first operand of a new bind
//   k_last     beat is the final operand
//   k_data_in  operand word slice
//   k_mode     00 XOR, 01 XNOR, 10 permute-bind, 11 reserved (XOR + err)
//   err_clr    clears the sticky error flag
//   k_data_out bound result, valid while k_done=1
//   k_ready    kernel accepts a beat this cycle
//   k_done     result valid and held
//   err        sticky protocol/mode error
module bind_kernel #(
  parameter int HV_DATA_WIDTH = 32,
  parameter int ROT_AMOUNT    = 1,
  parameter int LATENCY       = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     k_valid,
  input  logic                     k_first,
  input  logic                     k_last,
  input  logic [HV_DATA_WIDTH-1:0] k_data_in,
  input  logic [1:0]               k_mode,
  input  logic                     err_clr,
  output logic [HV_DATA_WIDTH-1:0] k_data_out,
  output logic                     k_ready,
  output logic                     k_done,
  output logic                     err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_XOR  = 2'b00;
  localparam logic [1:0] MODE_XNOR = 2'b01;
  localparam logic [1:0] MODE_PERM = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // BUSY lasts LATENCY-1 cycles, so the counter starts at LATENCY-2 and
  // DONE is entered on the cycle the counter reads zero.
  localparam logic [1:0] BUSY_LOAD = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  // Left-rotate by ROT_AMOUNT; the MSB wraps into the LSB.
  function automatic logic [HV_DATA_WIDTH-1:0] rotl(input logic [HV_DATA_WIDTH-1:0] a);
    logic [HV_DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < HV_DATA_WIDTH; i++) begin
      r[(i + ROT_AMOUNT) % HV_DATA_WIDTH] = a[i];
    end
    return r;
  endfunction

  // One fold step of the running accumulator with a new operand.
  function automatic logic [HV_DATA_WIDTH-1:0] fold(input logic [HV_DATA_WIDTH-1:0] acc,
                                                    input logic [HV_DATA_WIDTH-1:0] d,
                                                    input logic [1:0]               mode);
    logic [HV_DATA_WIDTH-1:0] r;
    case (mode)
      MODE_XNOR: r = ~(acc ^ d);
      MODE_PERM: r = rotl(acc) ^ d;
      default:   r = acc ^ d;
    endcase
    return r;
  endfunction

  state_t                   state_q, state_d;
  logic [HV_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [HV_DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]               mode_q, mode_d;
  logic [1:0]               cnt_q, cnt_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     accept_s;
  logic                     start_s;
  logic                     finish_s;
  logic                     err_ev_s;
  logic [HV_DATA_WIDTH-1:0] final_s;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    start_s    = 1'b0;
    finish_s   = 1'b0;
    err_ev_s   = 1'b0;
    accept_s   = k_valid & ready_q;
    // A single-operand bind passes its data through unmodified in every mode.
    final_s    = k_first ? k_data_in : fold(acc_q, k_data_in, mode_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s && k_first) begin
          start_s = 1'b1;
        end else if (accept_s) begin
          // Stray non-first beat (e.g. a re-presented buffered word): ignored.
          err_ev_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_ACCUM: begin
        if (accept_s && k_first) begin
          start_s  = 1'b1;
          err_ev_s = 1'b1;
        end else if (accept_s && k_last) begin
          finish_s = 1'b1;
        end else if (accept_s) begin
          acc_d = final_s;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d    = ST_DONE;
          data_out_d = acc_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_s) begin
      acc_d = k_data_in;
      if (k_mode == MODE_RSVD) begin
        mode_d   = MODE_XOR;
        err_ev_s = 1'b1;
      end else begin
        mode_d = k_mode;
      end
      if (k_last) begin
        finish_s = 1'b1;
      end else begin
        state_d = ST_ACCUM;
      end
    end else begin
      mode_d = mode_d;
    end

    if (finish_s) begin
      acc_d = final_s;
      if (LATENCY == 1) begin
        state_d    = ST_DONE;
        data_out_d = final_s;
      end else begin
        state_d = ST_BUSY;
        cnt_d   = BUSY_LOAD;
      end
    end else begin
      cnt_d = cnt_d;
    end

    ready_d = (state_d != ST_BUSY);
    done_d  = (state_d == ST_DONE);
    // A new error event in the same cycle as err_clr keeps err set.
    err_d   = err_ev_s | (err_q & ~err_clr);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      data_out_q <= '0;
      mode_q     <= MODE_XOR;
      cnt_q      <= 2'd0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign k_data_out = data_out_q;
  assign k_ready    = ready_q;
  assign k_done     = done_q;
  assign err        = err_q;

endmodule
